// File: rtl/ntt_stream_ctrl.sv
// ntt_stream_ctrl: streams N coefficients into the NTT core (mod-Q reduced),
// starts it, then drains results through a 2-deep FIFO with backpressure.
// Ports: s_* input stream, m_* output stream, ntt_* core load/start/read,
// err sticky frame/range flag, active = busy with a frame.
module ntt_stream_ctrl #(
  parameter int N          = 256,
  parameter int WIDTH      = 32,
  parameter int Q          = 8380417,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic                  ntt_load_coeff,
  output logic [ADDR_WIDTH-1:0] ntt_load_addr,
  output logic [WIDTH-1:0]      ntt_load_data,
  output logic                  ntt_start,
  input  logic                  ntt_done,
  output logic [ADDR_WIDTH-1:0] ntt_read_addr,
  input  logic [WIDTH-1:0]      ntt_read_data,
  output logic                  err,
  output logic                  active
);

  typedef enum logic [2:0] {
    LOAD, FLUSH, START, WAIT, DRAIN
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH:0] RD_END =
    (ADDR_WIDTH + 1)'(N);
  localparam logic [WIDTH:0] Q1 = (WIDTH + 1)'(Q);
  localparam logic [WIDTH:0] Q2 = (WIDTH + 1)'(2 * Q);

  state_e                state_q, state_d;
  logic                  run_q;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  ld_v_q, ld_v_d;
  logic [ADDR_WIDTH-1:0] ld_a_q, ld_a_d;
  logic [WIDTH-1:0]      ld_d_q, ld_d_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH:0]   rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] wr_q, wr_d;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [WIDTH-1:0]      fifo_q [2];
  logic                  hd_q, tl_q;
  logic [1:0]            cnt_q;

  logic                  accept, pop, push, issue;
  logic [2:0]            occ;
  logic [WIDTH:0]        s_ext;
  logic                  in_lo, in_mid, in_hi;
  logic [WIDTH-1:0]      red;
  logic                  red_bad, last_bad;

  assign s_ready = run_q && (state_q == LOAD);
  assign accept  = s_valid && s_ready;

  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = fifo_q[hd_q];
  assign m_last  = m_valid && (wr_q == LAST);
  assign pop     = m_valid && m_ready;
  assign push    = inflight_q;

  // Outstanding = buffered + in flight; a beat leaving this cycle
  // frees its slot, keeping the FIFO at most 2 deep.
  assign occ   = {1'b0, cnt_q} + {2'b0, inflight_q};
  assign issue = (state_q == DRAIN) && (rd_q < RD_END) &&
                 (occ < (3'd2 + {2'b0, pop}));

  assign ntt_read_addr  = issue ? rd_q[ADDR_WIDTH-1:0] : raddr_q;
  assign ntt_load_coeff = ld_v_q;
  assign ntt_load_addr  = ld_a_q;
  assign ntt_load_data  = ld_d_q;
  assign ntt_start      = (state_q == START);
  assign err            = err_q;
  assign active         = !((state_q == LOAD) && (idx_q == '0));

  assign s_ext  = {1'b0, s_data};
  assign in_lo  = (s_ext < Q1);
  assign in_hi  = (s_ext >= Q2);
  assign in_mid = !in_lo && !in_hi;

  assign last_bad = s_last ^ (idx_q == LAST);

  always_comb begin
    red     = '0;
    red_bad = 1'b0;
    unique case (1'b1)
      in_lo:   red = s_data;
      in_mid:  red = s_data - Q1[WIDTH-1:0];
      in_hi:   red_bad = 1'b1;
      default: red = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ld_v_d  = 1'b0;
    ld_a_d  = ld_a_q;
    ld_d_d  = ld_d_q;
    err_d   = err_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          ld_v_d = 1'b1;
          ld_a_d = idx_q;
          ld_d_d = red;
          if (red_bad || last_bad) err_d = 1'b1;
          if (idx_q == LAST) begin
            state_d = FLUSH;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FLUSH: state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        if (ntt_done) begin
          state_d = DRAIN;
          rd_d    = '0;
          wr_d    = '0;
        end
      end
      DRAIN: begin
        if (issue) rd_d = rd_q + 1'b1;
        if (pop) begin
          wr_d = wr_q + 1'b1;
          if (wr_q == LAST) begin
            state_d = LOAD;
            idx_d   = '0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      run_q      <= 1'b0;
      idx_q      <= '0;
      ld_v_q     <= 1'b0;
      ld_a_q     <= '0;
      ld_d_q     <= '0;
      err_q      <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      inflight_q <= 1'b0;
      raddr_q    <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      hd_q       <= 1'b0;
      tl_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      idx_q      <= idx_d;
      ld_v_q     <= ld_v_d;
      ld_a_q     <= ld_a_d;
      ld_d_q     <= ld_d_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      inflight_q <= issue;
      if (issue) raddr_q <= rd_q[ADDR_WIDTH-1:0];
      if (push) begin
        fifo_q[tl_q] <= ntt_read_data;
        tl_q         <= ~tl_q;
      end
      if (pop) hd_q <= ~hd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// tb_ntt_stream_ctrl: directed frames against ntt_stream_ctrl with a
// behavioural core model and a scoreboard-driven output monitor.
module tb_ntt_stream_ctrl;

  localparam int QM = 8380417;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic        m_valid, m_last;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        ntt_load_coeff, ntt_start, ntt_done;
  logic [7:0]  ntt_load_addr, ntt_read_addr;
  logic [31:0] ntt_load_data, ntt_read_data;
  logic        err, active;

  logic [31:0] cmem [256];
  exp_t        exp_q [$];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  acc_cnt, starts, start_cyc, popped, first_v;
  int  last_pop, early, ovf, t_acc;
  bit  done_seen, tog_mode;
  bit  hold_v;
  logic [31:0] hold_d;

  ntt_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last),
    .ntt_load_coeff(ntt_load_coeff),
    .ntt_load_addr(ntt_load_addr),
    .ntt_load_data(ntt_load_data),
    .ntt_start(ntt_start), .ntt_done(ntt_done),
    .ntt_read_addr(ntt_read_addr),
    .ntt_read_data(ntt_read_data),
    .err(err), .active(active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: port B writes, registered read returning x+1000.
  always @(posedge clk) begin
    if (ntt_load_coeff) cmem[ntt_load_addr] <= ntt_load_data;
    ntt_read_data <= cmem[ntt_read_addr] + 32'd1000;
  end

  always @(posedge clk) begin
    #1 m_ready = tog_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask

  function automatic logic [31:0] red(input logic [31:0] v);
    if (v < QM) return v;
    else if (v < 2 * QM) return v - QM;
    else return 32'd0;
  endfunction

  function automatic logic [31:0] in_val(input int kind, input int i);
    if (kind == 1 && i == 5) return QM + 7;
    if (kind == 1 && i == 6) return 2 * QM;
    return i;
  endfunction

  // Output monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (s_valid && s_ready) acc_cnt++;
      if (ntt_start) begin
        starts++;
        start_cyc = cyc;
      end
      if (hold_v) begin
        checks++;
        if (!m_valid || m_data !== hold_d) begin
          errors++;
          $display("FAIL hold got v=%0d d=%0d want v=1 d=%0d",
                   m_valid, m_data, hold_d);
        end
      end
      if (m_valid) begin
        if (!done_seen) early++;
        if (first_v < 0) first_v = cyc;
        if (int'(ntt_read_addr) + 1 - popped - int'(m_ready) > 2)
          ovf++;
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat got d=%0d with none expected", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e.d || m_last !== e.l) begin
            errors++;
            $display("FAIL beat%0d got d=%0d l=%0d want d=%0d l=%0d",
                     popped, m_data, m_last, e.d, e.l);
          end
        end
        popped++;
        last_pop = cyc;
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
    end
  end

  task automatic reset_vals();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_ld_coeff", ntt_load_coeff, 0);
    chk("rst_ld_addr", ntt_load_addr, 0);
    chk("rst_ld_data", ntt_load_data, 0);
    chk("rst_start", ntt_start, 0);
    chk("rst_rd_addr", ntt_read_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_active", active, 0);
  endtask

  task automatic send_frame(input int kind);
    int   i, w;
    exp_t e;
    logic [31:0] v;
    i = 0;
    w = 0;
    while (i < 256 && w < 100) begin
      @(posedge clk);
      #1;
      v       = in_val(kind, i);
      s_valid = 1'b1;
      s_data  = v;
      s_last  = (i == 255) || (kind == 2 && i == 100);
      ntt_done = (kind == 3 && i == 50);
      @(negedge clk);
      if (kind == 3 && i == 52) chk("spur_ready", s_ready, 1);
      if (s_ready) begin
        e.d = red(v) + 32'd1000;
        e.l = (i == 255);
        exp_q.push_back(e);
        if (i == 255) t_acc = cyc;
        i++;
        w = 0;
      end else begin
        w++;
      end
    end
    if (i < 256) chk("load_timeout", i, 256);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      ntt_done = 1'b0;
      s_valid  = 1'b1;
      s_data   = 32'h5a5a;
      s_last   = 1'b1;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
    chk("accepts", acc_cnt, 256);
    chk("start_lat", start_cyc - t_acc, 2);
  endtask

  task automatic run_frame(input int kind, input int lat,
                           input bit tog, input int stop_at);
    int d, k;
    acc_cnt   = 0;
    starts    = 0;
    start_cyc = -100;
    popped    = 0;
    first_v   = -1;
    done_seen = 1'b0;
    early     = 0;
    ovf       = 0;
    tog_mode  = tog;
    send_frame(kind);
    repeat (lat) @(posedge clk);
    #1 ntt_done = 1'b1;
    @(negedge clk);
    d = cyc;
    done_seen = 1'b1;
    @(posedge clk);
    #1 ntt_done = 1'b0;
    k = 0;
    while (popped < stop_at && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (stop_at < 256) begin
      chk("partial", popped, stop_at);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      reset_vals();
      exp_q.delete();
      popped = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end else begin
      chk("beats", popped, 256);
      repeat (5) @(negedge clk);
      chk("first_valid", first_v - d, 3);
      if (!tog) chk("drain_end", last_pop - d, 258);
      chk("outstanding", ovf, 0);
      chk("early_out", early, 0);
      chk("starts", starts, 1);
      chk("leftover", exp_q.size(), 0);
    end
    tog_mode = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    ntt_done = 1'b0;
    tog_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_vals();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", s_ready, 1);

    run_frame(0, 5, 1'b0, 256);
    chk("err_clean", err, 0);

    run_frame(1, 5, 1'b0, 256);
    chk("err_range", err, 1);
    chk("core5", cmem[5], 7);
    chk("core6", cmem[6], 0);
    chk("core7", cmem[7], 7);

    run_frame(0, 5, 1'b0, 256);
    chk("err_sticky", err, 1);

    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("err_cleared", err, 0);

    run_frame(2, 5, 1'b1, 256);
    chk("err_slast", err, 1);

    run_frame(3, 500, 1'b0, 256);

    run_frame(0, 5, 1'b0, 40);

    run_frame(0, 5, 1'b0, 256);
    chk("err_after_rst", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
